// File: rtl/color_reg_pkg.sv
// Shared definitions for the colour-register AXI4-Lite responder:
// response codes, write-channel state encoding and the byte-lane merge.
package color_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_WAIT_AW = 2'd1,
    WR_WAIT_W  = 2'd2,
    WR_RESP    = 2'd3
  } wr_state_t;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/color_reg_axil_slave.sv
// AXI4-Lite responder holding the PPU colour registers; exposes them as a flat
// vector and pulses a per-register strobe whenever a write commits.
//
// state      | meaning
// WR_IDLE    | ready for AW and W; both together commit immediately
// WR_WAIT_AW | W captured, waiting for the address
// WR_WAIT_W  | AW captured, waiting for the data
// WR_RESP    | write committed, holding BVALID/BRESP until BREADY
module color_reg_axil_slave
  import color_reg_pkg::*;
#(
  parameter int          NUM_REGS  = 4,
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
  input  logic [2:0]               S_AXI_AWPROT,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
  input  logic [2:0]               S_AXI_ARPROT,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic [32*NUM_REGS-1:0]   color_regs_o,
  output logic [NUM_REGS-1:0]      reg_upd_o
);

  localparam int          IDX_W      = ADDR_W - 2;
  localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);

  wr_state_t        wr_state, wr_next;
  logic [IDX_W-1:0] aw_idx_q;
  logic [31:0]      w_data_q;
  logic [3:0]       w_strb_q;
  logic [1:0]       bresp_q;
  logic             aw_hs, w_hs, commit;
  logic [IDX_W-1:0] cm_idx;
  logic [31:0]      cm_data;
  logic [3:0]       cm_strb;
  logic             cm_in_range;

  logic [31:0]         regs [NUM_REGS];
  logic [NUM_REGS-1:0] upd_q;

  logic [IDX_W-1:0] ar_idx;
  logic             ar_in_range, ar_hs;
  logic [31:0]      rd_word;
  logic             arready_q, rvalid_q;
  logic [31:0]      rdata_q;
  logic [1:0]       rresp_q;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) wr_state <= WR_IDLE;
    else          wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    commit  = 1'b0;
    unique case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          commit  = 1'b1;
          wr_next = WR_RESP;
        end else if (aw_hs) begin
          wr_next = WR_WAIT_W;
        end else if (w_hs) begin
          wr_next = WR_WAIT_AW;
        end
      end
      WR_WAIT_W: begin
        if (w_hs) begin
          commit  = 1'b1;
          wr_next = WR_RESP;
        end
      end
      WR_WAIT_AW: begin
        if (aw_hs) begin
          commit  = 1'b1;
          wr_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (S_AXI_BREADY) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    unique case (wr_state)
      WR_IDLE: begin
        S_AXI_AWREADY = 1'b1;
        S_AXI_WREADY  = 1'b1;
      end
      WR_WAIT_W:  S_AXI_WREADY  = 1'b1;
      WR_WAIT_AW: S_AXI_AWREADY = 1'b1;
      WR_RESP:    S_AXI_BVALID  = 1'b1;
      default: ;
    endcase
  end

  // Commit operands come from the live bus or from whichever half was parked.
  always_comb begin
    cm_idx      = (wr_state == WR_WAIT_W)  ? aw_idx_q : S_AXI_AWADDR[ADDR_W-1:2];
    cm_data     = (wr_state == WR_WAIT_AW) ? w_data_q : S_AXI_WDATA;
    cm_strb     = (wr_state == WR_WAIT_AW) ? w_strb_q : S_AXI_WSTRB;
    cm_in_range = 32'(cm_idx) < NUM_REGS_U;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (wr_state == WR_IDLE && aw_hs && !w_hs) aw_idx_q <= S_AXI_AWADDR[ADDR_W-1:2];
      if (wr_state == WR_IDLE && w_hs && !aw_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (commit) bresp_q <= cm_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign S_AXI_BRESP = bresp_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VAL;
      upd_q <= '0;
    end else begin
      upd_q <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (commit && 32'(cm_idx) == 32'(k)) begin
          regs[k]  <= strb_merge(regs[k], cm_data, cm_strb);
          upd_q[k] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign color_regs_o[32*g +: 32] = regs[g];
  end
  assign reg_upd_o = upd_q;

  assign ar_idx      = S_AXI_ARADDR[ADDR_W-1:2];
  assign ar_in_range = 32'(ar_idx) < NUM_REGS_U;
  assign ar_hs       = S_AXI_ARVALID & arready_q;

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (32'(ar_idx) == 32'(k)) rd_word = regs[k];
    end
  end

  // regs is sampled before any same-edge commit lands, so a racing read sees the old value.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else if (ar_hs) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b1;
      rdata_q   <= ar_in_range ? rd_word : 32'h0;
      rresp_q   <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && S_AXI_RREADY) begin
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
    end else if (!rvalid_q) begin
      arready_q <= 1'b1;
    end
  end

  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_color_reg_axil_slave.sv
// Scoreboard bench for color_reg_axil_slave: tasks push expected B/R/strobe
// results into queues, a negedge monitor pops and compares them.
module tb_color_reg_axil_slave;

  localparam int NR   = 4;
  localparam int AW   = 6;
  localparam int MI_W = $clog2(NR);

  logic             ACLK = 1'b0;
  logic             ARESETN = 1'b0;
  logic [AW-1:0]    S_AXI_AWADDR = '0;
  logic [2:0]       S_AXI_AWPROT = '0;
  logic             S_AXI_AWVALID = 1'b0;
  logic             S_AXI_AWREADY;
  logic [31:0]      S_AXI_WDATA = '0;
  logic [3:0]       S_AXI_WSTRB = '0;
  logic             S_AXI_WVALID = 1'b0;
  logic             S_AXI_WREADY;
  logic [1:0]       S_AXI_BRESP;
  logic             S_AXI_BVALID;
  logic             S_AXI_BREADY = 1'b0;
  logic [AW-1:0]    S_AXI_ARADDR = '0;
  logic [2:0]       S_AXI_ARPROT = '0;
  logic             S_AXI_ARVALID = 1'b0;
  logic             S_AXI_ARREADY;
  logic [31:0]      S_AXI_RDATA;
  logic [1:0]       S_AXI_RRESP;
  logic             S_AXI_RVALID;
  logic             S_AXI_RREADY = 1'b0;
  logic [32*NR-1:0] color_regs_o;
  logic [NR-1:0]    reg_upd_o;

  color_reg_axil_slave #(.NUM_REGS(NR), .ADDR_W(AW), .RESET_VAL(32'h0)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .color_regs_o(color_regs_o), .reg_upd_o(reg_upd_o)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [1:0]       resp;
    logic [32*NR-1:0] regs;
  } b_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  int            checks = 0;
  int            errors = 0;
  b_exp_t        b_q[$];
  r_exp_t        r_q[$];
  logic [NR-1:0] upd_q[$];
  logic [31:0]   model [NR];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no handshake expected one within the cycle budget", name);
  endtask

  function automatic logic [32*NR-1:0] model_vec();
    logic [32*NR-1:0] v;
    for (int k = 0; k < NR; k++) v[32*k +: 32] = model[k];
    return v;
  endfunction

  // Monitor: compares every response/strobe the DUT presents against the queues.
  initial begin
    forever begin
      @(negedge ACLK);
      if (ARESETN) begin
        if (S_AXI_BVALID && S_AXI_BREADY) begin
          if (b_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_b: got BRESP %0h expected no response", S_AXI_BRESP);
          end else begin
            b_exp_t eb;
            eb = b_q.pop_front();
            chk("bresp", 128'(S_AXI_BRESP), 128'(eb.resp));
            chk("regs_at_b", 128'(color_regs_o), 128'(eb.regs));
          end
        end
        if (S_AXI_RVALID && S_AXI_RREADY) begin
          if (r_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_r: got RDATA %0h expected no response", S_AXI_RDATA);
          end else begin
            r_exp_t er;
            er = r_q.pop_front();
            chk("rdata", 128'(S_AXI_RDATA), 128'(er.data));
            chk("rresp", 128'(S_AXI_RRESP), 128'(er.resp));
          end
        end
        if (reg_upd_o != '0) begin
          if (upd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_upd: got %b expected no pulse", reg_upd_o);
          end else begin
            logic [NR-1:0] eu;
            eu = upd_q.pop_front();
            chk("reg_upd", 128'(reg_upd_o), 128'(eu));
          end
        end
      end
    end
  end

  // Tasks enter and leave 2 time units after a rising edge.
  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead,
                           input int b_delay, input bit probe);
    int            aw_start, w_start, cyc;
    bit            aw_done, w_done, b_done;
    logic [31:0]   mask;
    logic [MI_W-1:0] mi;
    b_exp_t        e;
    if (int'(addr[AW-1:2]) < NR) begin
      mi   = addr[MI_W+1:2];
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      model[mi] = (model[mi] & ~mask) | (data & mask);
      upd_q.push_back(NR'(1) << mi);
      e.resp = 2'b00;
    end else begin
      e.resp = 2'b10;
    end
    e.regs = model_vec();
    b_q.push_back(e);

    aw_start = (w_lead > 0) ? w_lead : 0;
    w_start  = (w_lead < 0) ? -w_lead : 0;
    S_AXI_AWADDR = addr;
    S_AXI_WDATA  = data;
    S_AXI_WSTRB  = strb;
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      S_AXI_AWVALID = !aw_done && (cyc >= aw_start);
      S_AXI_WVALID  = !w_done && (cyc >= w_start);
      @(negedge ACLK);
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
      if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1;
      @(posedge ACLK); #2;
      cyc++;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    if (!(aw_done && w_done)) timeout("write_addr_data");

    b_done = 0; cyc = 0;
    while (!b_done && cyc < 60) begin
      S_AXI_BREADY = (cyc >= b_delay);
      @(negedge ACLK);
      if (probe && cyc < b_delay) begin
        chk("stall_bvalid", 128'(S_AXI_BVALID), 128'(1));
        chk("stall_bresp", 128'(S_AXI_BRESP), 128'(e.resp));
        chk("stall_awready", 128'(S_AXI_AWREADY), 128'(0));
        chk("stall_wready", 128'(S_AXI_WREADY), 128'(0));
      end
      if (S_AXI_BVALID && S_AXI_BREADY) b_done = 1;
      @(posedge ACLK); #2;
      cyc++;
    end
    S_AXI_BREADY = 1'b0;
    if (!b_done) timeout("write_resp");
    @(negedge ACLK);
    chk("single_bvalid", 128'(S_AXI_BVALID), 128'(0));
    @(posedge ACLK); #2;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int r_delay);
    r_exp_t e;
    int     cyc;
    bit     done;
    if (int'(addr[AW-1:2]) < NR) begin
      e.data = model[addr[MI_W+1:2]];
      e.resp = 2'b00;
    end else begin
      e.data = 32'h0;
      e.resp = 2'b10;
    end
    r_q.push_back(e);
    S_AXI_ARADDR = addr;
    done = 0; cyc = 0;
    while (!done && cyc < 50) begin
      S_AXI_ARVALID = 1'b1;
      @(negedge ACLK);
      if (S_AXI_ARVALID && S_AXI_ARREADY) done = 1;
      @(posedge ACLK); #2;
      cyc++;
    end
    S_AXI_ARVALID = 1'b0;
    if (!done) timeout("read_addr");
    done = 0; cyc = 0;
    while (!done && cyc < 60) begin
      S_AXI_RREADY = (cyc >= r_delay);
      @(negedge ACLK);
      if (S_AXI_RVALID && S_AXI_RREADY) done = 1;
      @(posedge ACLK); #2;
      cyc++;
    end
    S_AXI_RREADY = 1'b0;
    if (!done) timeout("read_data");
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no end of test expected finish before 2ms");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    b_exp_t        eb;
    r_exp_t        er;

    for (int k = 0; k < NR; k++) model[k] = 32'h0;

    #100;
    chk("rst_regs", 128'(color_regs_o), 128'(0));
    chk("rst_awready", 128'(S_AXI_AWREADY), 128'(1));
    chk("rst_wready", 128'(S_AXI_WREADY), 128'(1));
    chk("rst_arready", 128'(S_AXI_ARREADY), 128'(0));
    chk("rst_bvalid", 128'(S_AXI_BVALID), 128'(0));
    chk("rst_rvalid", 128'(S_AXI_RVALID), 128'(0));
    chk("rst_rdata", 128'(S_AXI_RDATA), 128'(0));
    chk("rst_upd", 128'(reg_upd_o), 128'(0));
    #100;
    @(posedge ACLK); #2;
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("arready_before_edge", 128'(S_AXI_ARREADY), 128'(0));
    @(negedge ACLK);
    chk("arready_after_edge", 128'(S_AXI_ARREADY), 128'(1));
    @(posedge ACLK); #2;

    for (int k = 0; k < 4; k++) axi_read(AW'(4 * k), 0);

    for (int k = 0; k < 4; k++) axi_write(AW'(4 * k), 32'(k + 1), 4'hF, 0, 0, 0);
    for (int k = 0; k < 4; k++) axi_read(AW'(4 * k), 1);
    chk("flat_vector", 128'(color_regs_o), 128'h00000004_00000003_00000002_00000001);

    axi_write(6'h08, 32'hDEAD_BEEF, 4'b0101, 3, 0, 0);
    chk("w_first_reg2", 128'(color_regs_o[64 +: 32]), 128'(32'h00AD_00EF));

    axi_write(6'h0C, 32'h1357_9BDF, 4'hF, -2, 5, 1);
    axi_write(6'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    axi_read(6'h10, 0);
    axi_write(6'h3C, 32'hFFFF_FFFF, 4'hF, 1, 2, 1);
    axi_read(6'h3E, 2);
    axi_write(6'h05, 32'hAAAA_5555, 4'h0, 0, 0, 0);
    axi_write(6'h07, 32'h0BAD_F00D, 4'b1010, 0, 0, 0);
    axi_read(6'h06, 0);

    // Read racing a commit to the same register returns the pre-write value.
    er.data = model[1];
    er.resp = 2'b00;
    r_q.push_back(er);
    model[1] = 32'hCAFE_F00D;
    upd_q.push_back(NR'(2));
    eb.resp = 2'b00;
    eb.regs = model_vec();
    b_q.push_back(eb);
    S_AXI_AWADDR = 6'h04; S_AXI_WDATA = 32'hCAFE_F00D; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 6'h04;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    chk("race_readies", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b111));
    @(posedge ACLK); #2;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    repeat (3) begin
      @(posedge ACLK); #2;
    end
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;

    for (int n = 0; n < 60; n++) begin
      a = AW'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)), 0);
      else
        axi_read(a, int'($urandom_range(0, 3)));
    end

    // Reset while parked in WR_WAIT_W and with a read response stalled.
    S_AXI_AWADDR = 6'h08; S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    @(posedge ACLK); #2;
    S_AXI_AWVALID = 1'b0;
    S_AXI_ARADDR = 6'h00; S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    @(posedge ACLK); #2;
    S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    chk("pre_rst_rvalid", 128'(S_AXI_RVALID), 128'(1));
    chk("pre_rst_awready", 128'(S_AXI_AWREADY), 128'(0));
    #1;
    ARESETN = 1'b0;
    #1;
    chk("mid_rst_bvalid", 128'(S_AXI_BVALID), 128'(0));
    chk("mid_rst_rvalid", 128'(S_AXI_RVALID), 128'(0));
    chk("mid_rst_awready", 128'(S_AXI_AWREADY), 128'(1));
    chk("mid_rst_arready", 128'(S_AXI_ARREADY), 128'(0));
    chk("mid_rst_regs", 128'(color_regs_o), 128'(0));
    for (int k = 0; k < NR; k++) model[k] = 32'h0;
    #30;
    @(posedge ACLK); #2;
    ARESETN = 1'b1;
    @(posedge ACLK); #2;
    axi_write(6'h04, 32'h1234_5678, 4'hF, 0, 0, 0);
    axi_read(6'h04, 0);
    axi_read(6'h08, 0);
    axi_write(6'h08, 32'h0000_00A5, 4'b0001, 0, 0, 0);
    axi_read(6'h08, 1);

    repeat (3) begin
      @(posedge ACLK); #2;
    end
    chk("b_queue_drained", 128'(b_q.size()), 128'(0));
    chk("r_queue_drained", 128'(r_q.size()), 128'(0));
    chk("upd_queue_drained", 128'(upd_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
